mem_lsu: RTL and testbench

- Load/store unit directly upstream of the 32K x 16 data memory. It accepts single-word CPU load/store requests and decodes the address into two regions:
  - 0x0000-0x7FFF goes to the data memory, which has 1-cycle synchronous read latency.
  - 0x8000-0xFFFF goes to the memory-mapped IO bus (video control, gamepad, timers), which uses a req/ack handshake.
- It returns a registered one-cycle completion pulse to the CPU.
- An IO watchdog prevents a dead peripheral from hanging the CPU.

---
 rtl/mem_lsu_pkg.sv | 20 ++
 rtl/mem_lsu_if.sv | 44 ++++
 rtl/mem_lsu_watchdog.sv | 32 +++
 rtl/mem_lsu.sv | 147 ++++++++++++++
 tb/tb_mem_lsu.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_RD  = 2'd1,
    IO_WAIT = 2'd2
  } lsu_state_t;

  localparam int IO_REGION_BIT = 15;
  localparam int IO_ADDR_W     = 15;

  // Upper half of the word address space belongs to the IO bus
  function automatic logic is_io(input logic [15:0] addr);
    return addr[IO_REGION_BIT];
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU, data-memory and IO-bus signals of the load/store unit.
// Latency: none (wiring only).
// Backpressure: CPU holds request until cpu_ready; IO side uses req/ack.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  // CPU request / completion
  logic                 cpu_req;
  logic                 cpu_we;
  logic [15:0]          cpu_addr;
  logic [15:0]          cpu_wdata;
  logic                 cpu_ready;
  logic [15:0]          cpu_rdata;
  logic                 cpu_err;

  // Data memory (1-cycle synchronous read)
  logic                 mem_w_en;
  logic [15:0]          mem_addr;
  logic [15:0]          mem_data_write;
  logic [15:0]          mem_data_read;

  // Memory-mapped IO bus
  logic                 io_req;
  logic                 io_we;
  logic [IO_ADDR_W-1:0] io_addr;
  logic [15:0]          io_wdata;
  logic                 io_ack;
  logic [15:0]          io_rdata;

  // The load/store unit side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_read, io_ack, io_rdata,
    output cpu_ready, cpu_rdata, cpu_err, mem_w_en, mem_addr, mem_data_write,
           io_req, io_we, io_addr, io_wdata
  );

  // The environment side (CPU, memory and peripherals)
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_data_read, io_ack, io_rdata,
    input  cpu_ready, cpu_rdata, cpu_err, mem_w_en, mem_addr, mem_data_write,
           io_req, io_we, io_addr, io_wdata
  );

endinterface

// File: rtl/mem_lsu_watchdog.sv
// IO watchdog: counts IO wait cycles and flags the final allowed cycle.
// Latency: expired is combinational from the registered count.
// Backpressure: none; counting freezes once expired until cleared.
module mem_lsu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic sys_clock,
  input  logic sys_reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Clear on IO entry, count each wait cycle, hold at the last value
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit splitting CPU accesses between data RAM and the IO bus.
// Latency: RAM store 1, RAM load 2, IO ack+1 (or IO_TIMEOUT+1 on timeout).
// Backpressure: one transaction at a time; cpu_req ignored until cpu_ready.
import mem_lsu_pkg::*;

module mem_lsu #(
  parameter int          IO_TIMEOUT = 64,
  parameter logic [15:0] ERR_DATA   = 16'hFFFF
) (
  input  logic       sys_clock,
  input  logic       sys_reset,
  mem_lsu_if.slave   bus
);

  lsu_state_t           state;
  lsu_state_t           state_nxt;

  logic                 wd_clr;
  logic                 wd_en;
  logic                 wd_expired;

  logic                 cpu_ready_q;
  logic                 cpu_err_q;
  logic [15:0]          cpu_rdata_q;
  logic                 io_req_q;
  logic                 io_we_q;
  logic [IO_ADDR_W-1:0] io_addr_q;
  logic [15:0]          io_wdata_q;

  logic                 accept;
  logic                 accept_io;

  assign accept    = (state == IDLE) && bus.cpu_req;
  assign accept_io = accept && is_io(bus.cpu_addr);

  mem_lsu_watchdog #(
    .TIMEOUT (IO_TIMEOUT)
  ) u_watchdog (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .clr       (wd_clr),
    .en        (wd_en),
    .expired   (wd_expired)
  );

  // RAM is driven straight from the CPU so a store lands in its accept cycle
  assign bus.mem_addr       = bus.cpu_addr;
  assign bus.mem_data_write = bus.cpu_wdata;
  assign bus.mem_w_en       = accept && bus.cpu_we && !is_io(bus.cpu_addr) && !sys_reset;

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.io_req    = io_req_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = io_addr_q;
  assign bus.io_wdata  = io_wdata_q;

  // State register
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and watchdog control; stores to RAM never leave IDLE
  always_comb begin
    state_nxt = state;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_io) begin
          state_nxt = IO_WAIT;
          wd_clr    = 1'b1;
        end else if (accept && !bus.cpu_we) begin
          state_nxt = RAM_RD;
        end
      end
      RAM_RD: begin
        state_nxt = IDLE;
      end
      IO_WAIT: begin
        wd_en = 1'b1;
        if (bus.io_ack || wd_expired) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered completion, load data and IO request; ack beats timeout
  always_ff @(posedge sys_clock or posedge sys_reset) begin
    if (sys_reset) begin
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      cpu_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_io) begin
            io_req_q   <= 1'b1;
            io_we_q    <= bus.cpu_we;
            io_addr_q  <= bus.cpu_addr[IO_ADDR_W-1:0];
            io_wdata_q <= bus.cpu_wdata;
          end else if (accept && bus.cpu_we) begin
            cpu_ready_q <= 1'b1;
          end
        end
        RAM_RD: begin
          cpu_rdata_q <= bus.mem_data_read;
          cpu_ready_q <= 1'b1;
        end
        IO_WAIT: begin
          if (bus.io_ack) begin
            io_req_q    <= 1'b0;
            cpu_ready_q <= 1'b1;
            if (!io_we_q) begin
              cpu_rdata_q <= bus.io_rdata;
            end
          end else if (wd_expired) begin
            io_req_q    <= 1'b0;
            cpu_ready_q <= 1'b1;
            cpu_err_q   <= 1'b1;
            if (!io_we_q) begin
              cpu_rdata_q <= ERR_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a RAM model, scripted IO responder
// and a transaction-level reference model (expected latency/data/err).
module tb_mem_lsu;

  localparam int          TMO = 64;
  localparam logic [15:0] ERR = 16'hFFFF;

  logic sys_clock = 1'b0;
  logic sys_reset;
  always #5 sys_clock = ~sys_clock;

  mem_lsu_if bus();

  mem_lsu #(
    .IO_TIMEOUT (TMO),
    .ERR_DATA   (ERR)
  ) dut (
    .sys_clock (sys_clock),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;

  logic [15:0] ram [0:32767];

  always @(posedge sys_clock) cyc <= cyc + 1;

  // Data memory model: synchronous write, 1-cycle synchronous read
  always @(posedge sys_clock) begin
    if (bus.mem_w_en) begin
      ram[bus.mem_addr[14:0]] <= bus.mem_data_write;
      wr_count <= wr_count + 1;
    end
    bus.mem_data_read <= ram[bus.mem_addr[14:0]];
  end

  // Reference model state
  logic [15:0] ref_mem [int];
  int          stored_q[$];
  logic [15:0] exp_rdata;

  // Observations from the last transaction
  int          r_lat;
  logic [15:0] r_rdata;
  logic        r_err;
  int          r_wr;
  logic        r_io_seen;
  logic [14:0] r_io_addr;
  logic        r_io_we;
  logic [15:0] r_io_wdata;
  logic        r_io_req_at_ready;

  // Present one request at a negedge, answer IO if asked, return at the ready negedge
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int ack_idx, input logic [15:0] ack_data);
    int wr0;
    int io_cyc;
    bit done;
    wr0 = wr_count;
    io_cyc = 0;
    done = 0;
    r_io_seen = 0;
    r_lat = -1;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge sys_clock);
      bus.io_ack = 1'b0;
      if (bus.cpu_ready) begin
        r_lat = k;
        r_rdata = bus.cpu_rdata;
        r_err = bus.cpu_err;
        r_io_req_at_ready = bus.io_req;
        done = 1;
      end else if (bus.io_req) begin
        if (!r_io_seen) begin
          r_io_addr = bus.io_addr;
          r_io_we = bus.io_we;
          r_io_wdata = bus.io_wdata;
        end
        r_io_seen = 1'b1;
        if (io_cyc == ack_idx) begin
          bus.io_ack = 1'b1;
          bus.io_rdata = ack_data;
        end
        io_cyc++;
      end
    end
    bus.cpu_req = 1'b0;
    r_wr = wr_count - wr0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_no_ready: addr=%h got no cpu_ready within 300 cycles", addr);
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 16'hAAAA;
    bus.io_ack = 1'b0; bus.io_rdata = 16'h0;
    repeat (3) @(negedge sys_clock);
    checks++; if (bus.mem_w_en !== 1'b0) begin errors++; $display("FAIL reset_mem_w_en: got %b expected 0", bus.mem_w_en); end
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready: got %b expected 0", bus.cpu_ready); end
    checks++; if (bus.cpu_err !== 1'b0) begin errors++; $display("FAIL reset_cpu_err: got %b expected 0", bus.cpu_err); end
    checks++; if (bus.io_req !== 1'b0) begin errors++; $display("FAIL reset_io_req: got %b expected 0", bus.io_req); end
    checks++; if (bus.io_we !== 1'b0) begin errors++; $display("FAIL reset_io_we: got %b expected 0", bus.io_we); end
    checks++; if (bus.cpu_rdata !== 16'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0000", bus.cpu_rdata); end
    checks++; if (bus.io_addr !== 15'h0) begin errors++; $display("FAIL reset_io_addr: got %h expected 0000", bus.io_addr); end
    checks++; if (bus.io_wdata !== 16'h0) begin errors++; $display("FAIL reset_io_wdata: got %h expected 0000", bus.io_wdata); end
    checks++; if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0010", bus.mem_addr); end
    sys_reset = 1'b0;
    bus.cpu_req = 1'b0;
    exp_rdata = 16'h0;
    @(negedge sys_clock);
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_no_ready: got %b expected 0", bus.cpu_ready); end
  endtask

  task automatic test_ram_store_load();
    run_txn(1'b1, 16'h0010, 16'h1234, -1, 16'h0);
    ref_mem[16'h0010] = 16'h1234; stored_q.push_back(16'h0010);
    checks++; if (r_lat !== 0) begin errors++; $display("FAIL store_latency: got %0d expected 0", r_lat); end
    checks++; if (r_wr !== 1) begin errors++; $display("FAIL store_write_cycles: got %0d expected 1", r_wr); end
    checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL store_rdata_hold: got %h expected %h", r_rdata, exp_rdata); end
    @(negedge sys_clock);
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL store_ready_pulse: got %b expected 0", bus.cpu_ready); end
    run_txn(1'b0, 16'h0010, 16'h0, -1, 16'h0);
    exp_rdata = ref_mem[16'h0010];
    checks++; if (r_lat !== 1) begin errors++; $display("FAIL load_latency: got %0d expected 1", r_lat); end
    checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL load_rdata: got %h expected %h", r_rdata, exp_rdata); end
    checks++; if (r_wr !== 0) begin errors++; $display("FAIL load_no_write: got %0d expected 0", r_wr); end
    @(negedge sys_clock);
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL load_ready_pulse: got %b expected 0", bus.cpu_ready); end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    run_txn(1'b1, 16'h7FFF, 16'hBEEF, -1, 16'h0);
    ref_mem[16'h7FFF] = 16'hBEEF; stored_q.push_back(16'h7FFF);
    run_txn(1'b0, 16'h7FFF, 16'h0, -1, 16'h0);
    exp_rdata = ref_mem[16'h7FFF];
    checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_rdata: got %h expected %h", r_rdata, exp_rdata); end
    checks++; if (cyc - c0 !== 3) begin errors++; $display("FAIL b2b_cycles: got %0d expected 3", cyc - c0); end
  endtask

  task automatic test_io_load();
    run_txn(1'b0, 16'h8004, 16'h0, 3, 16'h00A5);
    exp_rdata = 16'h00A5;
    checks++; if (r_io_addr !== 15'h0004) begin errors++; $display("FAIL io_addr: got %h expected 0004", r_io_addr); end
    checks++; if (r_io_we !== 1'b0 || r_io_seen !== 1'b1) begin errors++; $display("FAIL io_we: got we=%b seen=%b expected 0/1", r_io_we, r_io_seen); end
    checks++; if (r_wr !== 0) begin errors++; $display("FAIL io_no_mem_write: got %0d expected 0", r_wr); end
    checks++; if (r_lat !== 4) begin errors++; $display("FAIL io_ack_latency: got %0d expected 4", r_lat); end
    checks++; if (r_rdata !== exp_rdata || r_err !== 1'b0) begin errors++; $display("FAIL io_rdata: got %h err=%b expected %h err=0", r_rdata, r_err, exp_rdata); end
    checks++; if (r_io_req_at_ready !== 1'b0) begin errors++; $display("FAIL io_req_drop: got %b expected 0", r_io_req_at_ready); end
    // A stray ack outside IO_WAIT must be ignored
    @(negedge sys_clock);
    bus.io_ack = 1'b1; bus.io_rdata = 16'h5555;
    @(negedge sys_clock);
    bus.io_ack = 1'b0;
    checks++; if (bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL stray_ack_ready: got %b expected 0", bus.cpu_ready); end
    @(negedge sys_clock);
    checks++; if (bus.cpu_rdata !== exp_rdata || bus.cpu_ready !== 1'b0) begin errors++; $display("FAIL stray_ack_rdata: got %h ready=%b expected %h ready=0", bus.cpu_rdata, bus.cpu_ready, exp_rdata); end
  endtask

  task automatic test_io_timeout();
    run_txn(1'b0, 16'h8123, 16'h0, -1, 16'h0);
    exp_rdata = ERR;
    checks++; if (r_lat !== TMO) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", r_lat, TMO); end
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", r_err); end
    checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL tmo_rdata: got %h expected %h", r_rdata, exp_rdata); end
    checks++; if (r_io_req_at_ready !== 1'b0) begin errors++; $display("FAIL tmo_io_req: got %b expected 0", r_io_req_at_ready); end
    @(negedge sys_clock);
    checks++; if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got ready=%b err=%b expected 0/0", bus.cpu_ready, bus.cpu_err); end
    // IO store: rdata must stay at the previous completion value
    run_txn(1'b1, 16'hC00F, 16'h4242, 0, 16'h1111);
    checks++; if (r_io_we !== 1'b1 || r_io_wdata !== 16'h4242) begin errors++; $display("FAIL io_store_bus: got we=%b wdata=%h expected 1/4242", r_io_we, r_io_wdata); end
    checks++; if (r_rdata !== exp_rdata || r_lat !== 1) begin errors++; $display("FAIL io_store_done: got rdata=%h lat=%0d expected %h/1", r_rdata, r_lat, exp_rdata); end
  endtask

  task automatic test_ack_final_cycle();
    run_txn(1'b0, 16'h8FFE, 16'h0, TMO - 1, 16'h3C3C);
    exp_rdata = 16'h3C3C;
    checks++; if (r_lat !== TMO) begin errors++; $display("FAIL ackfinal_latency: got %0d expected %0d", r_lat, TMO); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ackfinal_err: got %b expected 0", r_err); end
    checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL ackfinal_rdata: got %h expected %h", r_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid_io();
    int seen_ready;
    seen_ready = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h8000; bus.cpu_wdata = 16'h0;
    repeat (3) @(negedge sys_clock);
    checks++; if (bus.io_req !== 1'b1) begin errors++; $display("FAIL rstio_io_req_before: got %b expected 1", bus.io_req); end
    sys_reset = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    checks++; if (bus.io_req !== 1'b0) begin errors++; $display("FAIL rstio_io_req_drop: got %b expected 0", bus.io_req); end
    @(negedge sys_clock);
    sys_reset = 1'b0;
    exp_rdata = 16'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clock);
      if (bus.cpu_ready) seen_ready++;
    end
    checks++; if (seen_ready !== 0) begin errors++; $display("FAIL rstio_no_ready: got %0d pulses expected 0", seen_ready); end
    run_txn(1'b1, 16'h0000, 16'h0F0F, -1, 16'h0);
    ref_mem[16'h0000] = 16'h0F0F; stored_q.push_back(16'h0000);
    run_txn(1'b0, 16'h0000, 16'h0, -1, 16'h0);
    exp_rdata = ref_mem[16'h0000];
    checks++; if (r_rdata !== exp_rdata || r_lat !== 1) begin errors++; $display("FAIL rstio_after: got %h lat=%0d expected %h lat=1", r_rdata, r_lat, exp_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int kind;
      int exp_lat;
      int exp_wr;
      logic we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] adata;
      int dly;
      kind = $urandom_range(0, 3);
      if (kind == 1 && stored_q.size() == 0) kind = 0;
      wdata = 16'($urandom);
      adata = 16'($urandom);
      dly = $urandom_range(0, 12);
      we = 1'b0;
      exp_wr = 0;
      case (kind)
        0: begin we = 1'b1; addr = 16'($urandom_range(0, 32'h7FFF)); exp_lat = 0; exp_wr = 1; end
        1: begin addr = 16'(stored_q[$urandom_range(0, stored_q.size() - 1)]); exp_lat = 1; end
        2: begin addr = 16'h8000 | 16'($urandom_range(0, 32'h7FFF)); exp_lat = dly + 1; end
        default: begin we = 1'b1; addr = 16'h8000 | 16'($urandom_range(0, 32'h7FFF)); exp_lat = dly + 1; end
      endcase
      run_txn(we, addr, wdata, dly, adata);
      if (kind == 0) begin ref_mem[int'(addr)] = wdata; stored_q.push_back(int'(addr)); end
      if (kind == 1) exp_rdata = ref_mem[int'(addr)];
      if (kind == 2) exp_rdata = adata;
      checks++;
      if (r_lat !== exp_lat || r_rdata !== exp_rdata || r_err !== 1'b0 || r_wr !== exp_wr) begin
        errors++;
        $display("FAIL rand_txn%0d: addr=%h we=%b got lat=%0d rdata=%h err=%b wr=%0d expected lat=%0d rdata=%h err=0 wr=%0d",
                 n, addr, we, r_lat, r_rdata, r_err, r_wr, exp_lat, exp_rdata, exp_wr);
      end
      if (kind >= 2) begin
        checks++;
        if (r_io_addr !== addr[14:0] || r_io_we !== we || (we && r_io_wdata !== wdata)) begin
          errors++;
          $display("FAIL rand_io_bus%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   n, r_io_addr, r_io_we, r_io_wdata, addr[14:0], we, wdata);
        end
      end
      if ($urandom_range(0, 1) == 1) @(negedge sys_clock);
    end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
    bus.io_ack = 1'b0; bus.io_rdata = 16'h0;
    exp_rdata = 16'h0;
    test_reset();
    test_ram_store_load();
    test_back_to_back();
    test_io_load();
    test_io_timeout();
    test_ack_final_cycle();
    test_reset_mid_io();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
